// File: rtl/load_extend_controller.sv
// Load sequencer between the memory stage and the data memory port.
// It accepts one load request at a time and issues a word-aligned read.
// The addressed byte or halfword lane is selected (little-endian) and
// zero- or sign-extended to 32 bits. Misaligned, illegal-size and
// timed-out accesses return an error with RespData forced to zero.
module load_extend_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespError,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter value on the last cycle an ack is still accepted.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  offset_q, offset_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic        req_illegal;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] lane_ext;

  // Size/alignment legality of the incoming request.
  always_comb begin
    req_illegal = 1'b0;
    case (ReqSize)
      2'b00:   req_illegal = 1'b0;
      2'b01:   req_illegal = ReqAddr[0];
      2'b10:   req_illegal = (ReqAddr[1:0] != 2'b00);
      default: req_illegal = 1'b1;
    endcase
  end

  // Little-endian lane select of the read word, then zero/sign extension.
  always_comb begin
    byte_lane = MemRData[{offset_q, 3'b000} +: 8];
    half_lane = offset_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (size_q)
      2'b00:   lane_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   lane_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      default: lane_ext = MemRData;
    endcase
  end

  // Next-state and datapath update for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    size_d       = size_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          offset_d = ReqAddr[1:0];
          size_d   = ReqSize;
          signed_d = ReqSigned;
          if (req_illegal) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = {ReqAddr[31:2], 2'b00};
            cnt_d      = '0;
          end
        end
      end
      ACCESS: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (MemAck) begin
          state_d      = RESP;
          resp_data_d  = lane_ext;
          resp_error_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = RESP;
          resp_data_d  = '0;
          resp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      offset_q     <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign ReqReady  = (state_q == IDLE);
  assign Busy      = ~ReqReady;
  assign MemReq    = (state_q == ACCESS);
  assign MemAddr   = mem_addr_q;
  assign RespValid = (state_q == RESP);
  assign RespData  = resp_data_q;
  assign RespError = resp_error_q;

endmodule

// File: tb/tb_load_extend_controller.sv
// Directed bench for load_extend_controller, built with a 4-cycle timeout.
module tb_load_extend_controller;

  localparam int unsigned TO = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [31:0] ReqAddr = '0;
  logic [1:0]  ReqSize = '0;
  logic        ReqSigned = 1'b0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespError;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  load_extend_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemRData(MemRData),
    .RespValid(RespValid), .RespData(RespData), .RespError(RespError), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present a request for one edge (DUT must be idle); returns in cycle 1.
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic sg);
    ReqValid = 1'b1; ReqAddr = a; ReqSize = s; ReqSigned = sg;
    step();
    ReqValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset ReqReady: got %b want 1", ReqReady); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset Busy: got %b want 0", Busy); end
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL reset MemReq: got %b want 0", MemReq); end
    checks++; if (RespValid !== 1'b0 || RespError !== 1'b0) begin errors++; $display("FAIL reset resp: got v=%b e=%b want 0 0", RespValid, RespError); end
    checks++; if (RespData !== 32'h0 || MemAddr !== 32'h0) begin errors++; $display("FAIL reset data/addr: got %h %h want 0 0", RespData, MemAddr); end
    $display("reset: ReqReady=%b MemReq=%b RespData=%h", ReqReady, MemReq, RespData);
    Reset = 1'b0;
    step();
  endtask

  task automatic test_byte_signed();
    issue(32'h0000_1003, 2'b00, 1'b1);
    checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL byte MemReq c1: got %b want 1", MemReq); end
    checks++; if (MemAddr !== 32'h0000_1000) begin errors++; $display("FAIL byte MemAddr: got %h want 00001000", MemAddr); end
    MemAck = 1'b1; MemRData = 32'h80FF_FF12;
    step();
    MemAck = 1'b0;
    checks++; if (RespValid !== 1'b1) begin errors++; $display("FAIL byte RespValid c2: got %b want 1", RespValid); end
    checks++; if (RespData !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte RespData: got %h want ffffff80", RespData); end
    checks++; if (RespError !== 1'b0) begin errors++; $display("FAIL byte RespError: got %b want 0", RespError); end
    $display("load a=00001003 byte signed: data=%h err=%b", RespData, RespError);
    step();
    checks++; if (RespValid !== 1'b0 || ReqReady !== 1'b1) begin errors++; $display("FAIL byte c3: got v=%b rdy=%b want 0 1", RespValid, ReqReady); end
  endtask

  // Back-to-back loads: each issued in the first idle cycle after RESP.
  task automatic test_lanes();
    logic [31:0] addr [6];
    logic [1:0]  size [6];
    logic        sgn  [6];
    logic [31:0] rdat [6];
    logic [31:0] want [6];
    addr[0] = 32'h2002; size[0] = 2'b01; sgn[0] = 1'b0; rdat[0] = 32'hBEEF1234; want[0] = 32'h0000BEEF;
    addr[1] = 32'h2002; size[1] = 2'b01; sgn[1] = 1'b1; rdat[1] = 32'hBEEF1234; want[1] = 32'hFFFFBEEF;
    addr[2] = 32'h2000; size[2] = 2'b01; sgn[2] = 1'b1; rdat[2] = 32'hBEEF1234; want[2] = 32'h00001234;
    addr[3] = 32'h1001; size[3] = 2'b00; sgn[3] = 1'b0; rdat[3] = 32'h80FFFF12; want[3] = 32'h000000FF;
    addr[4] = 32'h1002; size[4] = 2'b00; sgn[4] = 1'b1; rdat[4] = 32'h807F0012; want[4] = 32'h0000007F;
    addr[5] = 32'h1008; size[5] = 2'b10; sgn[5] = 1'b1; rdat[5] = 32'h8000_0001; want[5] = 32'h80000001;
    for (int i = 0; i < 6; i++) begin
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL lane%0d ReqReady: got %b want 1", i, ReqReady); end
      issue(addr[i], size[i], sgn[i]);
      MemAck = 1'b1; MemRData = rdat[i];
      step();
      MemAck = 1'b0;
      checks++; if (RespValid !== 1'b1 || RespError !== 1'b0) begin errors++; $display("FAIL lane%0d resp: got v=%b e=%b want 1 0", i, RespValid, RespError); end
      checks++; if (RespData !== want[i]) begin errors++; $display("FAIL lane%0d RespData: got %h want %h", i, RespData, want[i]); end
      $display("load a=%h size=%0d signed=%b rdata=%h: data=%h", addr[i], size[i], sgn[i], rdat[i], RespData);
      step();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] addr [3];
    logic [1:0]  size [3];
    addr[0] = 32'h3001; size[0] = 2'b01;
    addr[1] = 32'h3002; size[1] = 2'b10;
    addr[2] = 32'h3000; size[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      issue(addr[i], size[i], 1'b1);
      checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL illegal%0d MemReq: got %b want 0", i, MemReq); end
      checks++; if (RespValid !== 1'b1 || RespError !== 1'b1) begin errors++; $display("FAIL illegal%0d resp c1: got v=%b e=%b want 1 1", i, RespValid, RespError); end
      checks++; if (RespData !== 32'h0) begin errors++; $display("FAIL illegal%0d RespData: got %h want 0", i, RespData); end
      $display("illegal a=%h size=%0d: err=%b data=%h", addr[i], size[i], RespError, RespData);
      step();
      checks++; if (MemReq !== 1'b0 || RespValid !== 1'b0 || ReqReady !== 1'b1) begin errors++; $display("FAIL illegal%0d c2: got req=%b v=%b rdy=%b want 0 0 1", i, MemReq, RespValid, ReqReady); end
    end
  endtask

  task automatic test_timeout();
    issue(32'h5000, 2'b10, 1'b0);
    for (int c = 1; c <= int'(TO); c++) begin
      checks++; if (MemReq !== 1'b1 || RespValid !== 1'b0) begin errors++; $display("FAIL timeout c%0d: got req=%b v=%b want 1 0", c, MemReq, RespValid); end
      step();
    end
    checks++; if (MemReq !== 1'b0 || RespValid !== 1'b1 || RespError !== 1'b1) begin errors++; $display("FAIL timeout resp: got req=%b v=%b e=%b want 0 1 1", MemReq, RespValid, RespError); end
    checks++; if (RespData !== 32'h0) begin errors++; $display("FAIL timeout RespData: got %h want 0", RespData); end
    $display("timeout a=00005000: err=%b data=%h", RespError, RespData);
    step();
    // Ack arriving on the last allowed cycle must still succeed.
    issue(32'h5004, 2'b10, 1'b0);
    for (int c = 1; c < int'(TO); c++) step();
    checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL lastack MemReq c4: got %b want 1", MemReq); end
    MemAck = 1'b1; MemRData = 32'hA5A5_0F0F;
    step();
    MemAck = 1'b0;
    checks++; if (RespValid !== 1'b1 || RespError !== 1'b0) begin errors++; $display("FAIL lastack resp: got v=%b e=%b want 1 0", RespValid, RespError); end
    checks++; if (RespData !== 32'hA5A5_0F0F) begin errors++; $display("FAIL lastack RespData: got %h want a5a50f0f", RespData); end
    $display("last-cycle ack a=00005004: err=%b data=%h", RespError, RespData);
    step();
  endtask

  task automatic test_reset_mid_access();
    issue(32'h4100, 2'b10, 1'b0);
    step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    MemAck = 1'b1; MemRData = 32'hDEAD_BEEF;
    checks++; if (MemReq !== 1'b0 || ReqReady !== 1'b1 || RespValid !== 1'b0) begin errors++; $display("FAIL midreset: got req=%b rdy=%b v=%b want 0 1 0", MemReq, ReqReady, RespValid); end
    checks++; if (RespData !== 32'h0 || MemAddr !== 32'h0) begin errors++; $display("FAIL midreset regs: got data=%h addr=%h want 0 0", RespData, MemAddr); end
    step();
    MemAck = 1'b0;
    checks++; if (RespValid !== 1'b0 || MemReq !== 1'b0) begin errors++; $display("FAIL midreset late ack: got v=%b req=%b want 0 0", RespValid, MemReq); end
    $display("reset mid-access: MemReq=%b RespValid=%b", MemReq, RespValid);
    issue(32'h4000, 2'b10, 1'b0);
    MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
    step();
    MemAck = 1'b0;
    checks++; if (RespValid !== 1'b1 || RespData !== 32'hCAFE_F00D || RespError !== 1'b0) begin errors++; $display("FAIL postreset load: got v=%b data=%h e=%b want 1 cafef00d 0", RespValid, RespData, RespError); end
    $display("load a=00004000 word: data=%h", RespData);
    step();
  endtask

  task automatic test_busy_reject();
    issue(32'h6001, 2'b00, 1'b0);
    ReqValid = 1'b1; ReqAddr = 32'h7000; ReqSize = 2'b10;
    checks++; if (ReqReady !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL busy flags: got rdy=%b busy=%b want 0 1", ReqReady, Busy); end
    step(); step();
    ReqValid = 1'b0;
    checks++; if (MemAddr !== 32'h6000 || MemReq !== 1'b1) begin errors++; $display("FAIL busy MemAddr: got %h req=%b want 00006000 1", MemAddr, MemReq); end
    MemAck = 1'b1; MemRData = 32'h1122_3344;
    step();
    MemAck = 1'b0;
    checks++; if (RespValid !== 1'b1 || RespData !== 32'h0000_0033) begin errors++; $display("FAIL busy resp: got v=%b data=%h want 1 00000033", RespValid, RespData); end
    $display("busy reject a=00006001 byte: data=%h", RespData);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (MemReq !== 1'b0 || RespValid !== 1'b0) begin errors++; $display("FAIL busy no-second c%0d: got req=%b v=%b want 0 0", c, MemReq, RespValid); end
    end
  endtask

  initial begin
    test_reset();
    test_byte_signed();
    test_lanes();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_busy_reject();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
